// File: rtl/axi_pkg.sv
// AXI4 write-channel types and constants shared by axi_write_responder,
// its FIFO sub-module and the testbench.
package axi_pkg;

  localparam int unsigned AXI_ID_WIDTH   = 4;
  localparam int unsigned AXI_ADDR_WIDTH = 32;
  localparam int unsigned AXI_DATA_WIDTH = 32;
  localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

  typedef logic [7:0]              len_t;
  typedef logic [2:0]              size_t;
  typedef logic [1:0]              burst_t;
  typedef logic [1:0]              resp_t;
  typedef logic [AXI_ID_WIDTH-1:0] id_t;

  localparam burst_t BURST_FIXED = 2'b00;
  localparam burst_t BURST_INCR  = 2'b01;
  localparam burst_t BURST_WRAP  = 2'b10;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;

  typedef struct packed {
    id_t                       id;
    logic [AXI_ADDR_WIDTH-1:0] addr;
    len_t                      len;
    size_t                     size;
    burst_t                    burst;
  } aw_chan_t;

  typedef struct packed {
    logic [AXI_DATA_WIDTH-1:0] data;
    logic [AXI_STRB_WIDTH-1:0] strb;
    logic                      last;
  } w_chan_t;

  typedef struct packed {
    id_t   id;
    resp_t resp;
  } b_chan_t;

  // W-path state: IDLE loads the next burst from the AW head, BURST accepts beats.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } wr_state_e;

endpackage

// File: rtl/axi_wr_resp_fifo.sv
// Synchronous FIFO used for the AW queue and the B queue of axi_write_responder.
// No fall-through: a pushed entry becomes visible at the head one cycle later.
// The head reads as zero while the FIFO is empty so downstream outputs stay clean.
module axi_wr_resp_fifo #(
  parameter type         data_t = logic [7:0],
  parameter int unsigned DEPTH  = 4
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  push_i,
  input  data_t data_i,
  input  logic  pop_i,
  output data_t data_o,
  output logic  full_o,
  output logic  empty_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  data_t           mem [DEPTH];
  logic [PtrW-1:0] wr_ptr_reg;
  logic [PtrW-1:0] rd_ptr_reg;
  logic [CntW-1:0] count_reg;
  logic            do_push;
  logic            do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_reg == CntW'(DEPTH));
  assign empty_o = (count_reg == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = empty_o ? '0 : mem[rd_ptr_reg];

  // Storage array: written on accepted pushes, no reset needed.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= data_i;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/axi_write_responder.sv
// Terminating AXI4 write endpoint: queues AW requests, turns each accepted W
// beat into a one-cycle memory write strobe, and returns one B per burst in
// AW order.
// Optional feature macro: AXI_WRITE_RESPONDER_LEN_CHECK_EN -- when defined, a
// burst whose W.last does not coincide with beat len+1 is answered SLVERR;
// otherwise every response is OKAY.
module axi_write_responder
  import axi_pkg::*;
#(
  parameter type         aw_t      = axi_pkg::aw_chan_t,
  parameter type         w_t       = axi_pkg::w_chan_t,
  parameter type         b_t       = axi_pkg::b_chan_t,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned MaxTxns   = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   aw_valid_i,
  input  aw_t                    aw_chan_i,
  output logic                   aw_ready_o,
  input  logic                   w_valid_i,
  input  w_t                     w_chan_i,
  output logic                   w_ready_o,
  output logic                   b_valid_o,
  output b_t                     b_chan_o,
  input  logic                   b_ready_i,
  output logic                   wr_valid_o,
  output logic [AddrWidth-1:0]   wr_addr_o,
  output logic [DataWidth-1:0]   wr_data_o,
  output logic [DataWidth/8-1:0] wr_strb_o
);

  localparam int unsigned StrbWidth = DataWidth / 8;

  aw_t                  aw_head;
  logic                 aw_full;
  logic                 aw_empty;
  logic                 aw_pop;
  b_t                   b_in;
  logic                 b_push;
  logic                 b_full;
  logic                 b_empty;

  wr_state_e            state_reg;
  wr_state_e            state_next;
  logic                 ports_en_reg;
  logic [AddrWidth-1:0] addr_reg;
  logic [AddrWidth-1:0] addr_next;
  len_t                 cnt_reg;
  logic                 beat;
  logic                 len_hit;
  logic                 burst_end;
  resp_t                resp;

  logic                 wr_valid_reg;
  logic [AddrWidth-1:0] wr_addr_reg;
  logic [DataWidth-1:0] wr_data_reg;
  logic [StrbWidth-1:0] wr_strb_reg;

  axi_wr_resp_fifo #(.data_t(aw_t), .DEPTH(MaxTxns)) u_aw_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (aw_valid_i && aw_ready_o),
    .data_i  (aw_chan_i),
    .pop_i   (aw_pop),
    .data_o  (aw_head),
    .full_o  (aw_full),
    .empty_o (aw_empty)
  );

  axi_wr_resp_fifo #(.data_t(b_t), .DEPTH(MaxTxns)) u_b_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (b_push),
    .data_i  (b_in),
    .pop_i   (b_valid_o && b_ready_i),
    .data_o  (b_chan_o),
    .full_o  (b_full),
    .empty_o (b_empty)
  );

  // State register; ports_en_reg keeps aw_ready low through the reset cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= ST_IDLE;
      ports_en_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ports_en_reg <= 1'b1;
    end
  end

  // Next state: start a burst once an AW is queued, leave it at burst end.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (!aw_empty) state_next = ST_BURST;
      ST_BURST: if (burst_end) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Handshake outputs and burst-termination decode. Ready never looks at valid.
  always_comb begin
    aw_ready_o = ports_en_reg && !aw_full;
    w_ready_o  = (state_reg == ST_BURST) && !b_full;
    beat       = w_valid_i && w_ready_o;
    len_hit    = (cnt_reg == aw_head.len);
    burst_end  = beat && (w_chan_i.last || len_hit);
    aw_pop     = burst_end;
    b_push     = burst_end;
`ifdef AXI_WRITE_RESPONDER_LEN_CHECK_EN
    resp       = (w_chan_i.last && len_hit) ? RESP_OKAY : RESP_SLVERR;
`else
    resp       = RESP_OKAY;
`endif
    b_in       = '0;
    b_in.id    = aw_head.id;
    b_in.resp  = resp;
  end

  // Address generator: FIXED holds, INCR steps by the beat size, WRAP steps
  // and folds back into the aligned (len+1)<<size window.
  always_comb begin
    logic [AddrWidth-1:0] step;
    logic [AddrWidth-1:0] wrap_mask;
    logic [AddrWidth-1:0] incr_addr;
    step      = AddrWidth'(1) << aw_head.size;
    wrap_mask = ((AddrWidth'({1'b0, aw_head.len}) + AddrWidth'(1)) << aw_head.size) - AddrWidth'(1);
    incr_addr = addr_reg + step;
    addr_next = addr_reg;
    case (aw_head.burst)
      BURST_INCR: addr_next = incr_addr;
      BURST_WRAP: addr_next = (addr_reg & ~wrap_mask) | (incr_addr & wrap_mask);
      default:    addr_next = addr_reg;
    endcase
  end

  // Beat datapath: load the burst start in IDLE, register each accepted beat.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_reg     <= '0;
      cnt_reg      <= '0;
      wr_valid_reg <= 1'b0;
      wr_addr_reg  <= '0;
      wr_data_reg  <= '0;
      wr_strb_reg  <= '0;
    end else begin
      wr_valid_reg <= beat;
      if (state_reg == ST_IDLE && !aw_empty) begin
        addr_reg <= AddrWidth'(aw_head.addr);
        cnt_reg  <= '0;
      end
      if (beat) begin
        wr_addr_reg <= addr_reg;
        wr_data_reg <= DataWidth'(w_chan_i.data);
        wr_strb_reg <= StrbWidth'(w_chan_i.strb);
        addr_reg    <= addr_next;
        cnt_reg     <= cnt_reg + 1'b1;
      end
    end
  end

  assign b_valid_o  = !b_empty;
  assign wr_valid_o = wr_valid_reg;
  assign wr_addr_o  = wr_addr_reg;
  assign wr_data_o  = wr_data_reg;
  assign wr_strb_o  = wr_strb_reg;

endmodule

// File: tb/tb_axi_write_responder.sv
// Randomized self-checking bench for axi_write_responder. Expected writes and
// responses are computed per burst from the AXI addressing rules.
`timescale 1ns/1ps
module tb_axi_write_responder;
  import axi_pkg::*;

  localparam bit LenCheck =
`ifdef AXI_WRITE_RESPONDER_LEN_CHECK_EN
    1'b1;
`else
    1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        aw_valid_i = 1'b0;
  aw_chan_t    aw_chan_i = '0;
  logic        aw_ready_o;
  logic        w_valid_i = 1'b0;
  w_chan_t     w_chan_i = '0;
  logic        w_ready_o;
  logic        b_valid_o;
  b_chan_t     b_chan_o;
  logic        b_ready_i = 1'b0;
  logic        wr_valid_o;
  logic [31:0] wr_addr_o;
  logic [31:0] wr_data_o;
  logic [3:0]  wr_strb_o;

  always #5 clk = ~clk;

  axi_write_responder dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .aw_valid_i (aw_valid_i),
    .aw_chan_i  (aw_chan_i),
    .aw_ready_o (aw_ready_o),
    .w_valid_i  (w_valid_i),
    .w_chan_i   (w_chan_i),
    .w_ready_o  (w_ready_o),
    .b_valid_o  (b_valid_o),
    .b_chan_o   (b_chan_o),
    .b_ready_i  (b_ready_i),
    .wr_valid_o (wr_valid_o),
    .wr_addr_o  (wr_addr_o),
    .wr_data_o  (wr_data_o),
    .wr_strb_o  (wr_strb_o)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_exp_t;

  aw_chan_t aw_drv_q[$];
  w_chan_t  w_drv_q[$];
  wr_exp_t  exp_wr_q[$];
  b_chan_t  exp_b_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit aw_en = 0, w_en = 0, rand_valid = 0;
  int b_mode = 0;  // 0: hold low, 1: always ready, 2: random
  bit aw_fired = 0, w_fired = 0;
  int aw_acc = 0, w_acc = 0, wr_pulses = 0;
  int aw_fire_cyc = 0, w_fire_cyc = 0, wr_cyc = 0, b_rise_cyc = 0;
  bit b_held = 0, b_prev_valid = 0;
  b_chan_t b_prev = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Address of beat i of a burst, straight from the AXI burst definitions.
  function automatic logic [31:0] beat_addr(input logic [31:0] a, input int len, input int size,
                                            input logic [1:0] burst, input int i);
    longint unsigned bytes, win, base, av;
    bytes = longint'(1) << size;
    win   = longint'(len + 1) * bytes;
    av    = longint'(a);
    if (burst == BURST_FIXED) return a;
    if (burst == BURST_WRAP) begin
      base = av - (av % win);
      return 32'(base + ((av - base) + longint'(i) * bytes) % win);
    end
    return 32'(av + longint'(i) * bytes);
  endfunction

  task automatic add_burst(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input int size, input logic [1:0] burst, input int last_idx,
                           input logic [31:0] first_data);
    aw_chan_t aw;
    w_chan_t  w;
    wr_exp_t  e;
    b_chan_t  b;
    aw = '0;
    aw.id = id; aw.addr = addr; aw.len = 8'(len); aw.size = 3'(size); aw.burst = burst;
    aw_drv_q.push_back(aw);
    for (int i = 0; i <= last_idx; i++) begin
      if (i == 0 && first_data != 0) begin
        w.data = first_data; w.strb = 4'hF;
      end else begin
        w.data = $urandom; w.strb = 4'($urandom_range(15));
      end
      w.last = (i == last_idx);
      w_drv_q.push_back(w);
      e.addr = beat_addr(addr, len, size, burst, i);
      e.data = w.data;
      e.strb = w.strb;
      exp_wr_q.push_back(e);
    end
    b.id   = id;
    b.resp = (last_idx == len || !LenCheck) ? RESP_OKAY : RESP_SLVERR;
    exp_b_q.push_back(b);
  endtask

  // Sample everything at the falling edge and score it.
  task automatic monitor();
    wr_exp_t e;
    b_chan_t eb;
    aw_fired = aw_valid_i && aw_ready_o;
    w_fired  = w_valid_i && w_ready_o;
    if (aw_fired) begin
      if (aw_drv_q.size() > 0) void'(aw_drv_q.pop_front());
      aw_acc++; aw_fire_cyc = cyc;
    end
    if (w_fired) begin
      if (w_drv_q.size() > 0) void'(w_drv_q.pop_front());
      w_acc++; w_fire_cyc = cyc;
    end
    if (wr_valid_o === 1'b1) begin
      wr_pulses++; wr_cyc = cyc;
      if (exp_wr_q.size() == 0) check("wr_unexpected", 64'(wr_valid_o), 0);
      else begin
        e = exp_wr_q.pop_front();
        $display("wr   addr=%08h data=%08h strb=%h", wr_addr_o, wr_data_o, wr_strb_o);
        check("wr_addr", 64'(wr_addr_o), 64'(e.addr));
        check("wr_data", 64'(wr_data_o), 64'(e.data));
        check("wr_strb", 64'(wr_strb_o), 64'(e.strb));
      end
    end
    if (b_valid_o === 1'b1) begin
      if (!b_prev_valid) b_rise_cyc = cyc;
      if (b_held) check("b_stable", 64'(b_chan_o), 64'(b_prev));
      if (b_ready_i) begin
        if (exp_b_q.size() == 0) check("b_unexpected", 64'(b_valid_o), 0);
        else begin
          eb = exp_b_q.pop_front();
          $display("b    id=%0d resp=%0d", b_chan_o.id, b_chan_o.resp);
          check("b_id", 64'(b_chan_o.id), 64'(eb.id));
          check("b_resp", 64'(b_chan_o.resp), 64'(eb.resp));
        end
      end
    end
    b_held       = (b_valid_o === 1'b1) && !b_ready_i;
    b_prev       = b_chan_o;
    b_prev_valid = (b_valid_o === 1'b1);
  endtask

  // Drive the next input values just after the rising edge.
  task automatic drive();
    if (!(aw_valid_i && !aw_fired)) begin
      aw_valid_i = aw_en && aw_drv_q.size() > 0 && (!rand_valid || $urandom_range(3) != 0);
      aw_chan_i  = (aw_drv_q.size() > 0) ? aw_drv_q[0] : '0;
    end
    if (!(w_valid_i && !w_fired)) begin
      w_valid_i = w_en && w_drv_q.size() > 0 && (!rand_valid || $urandom_range(3) != 0);
      w_chan_i  = (w_drv_q.size() > 0) ? w_drv_q[0] : '0;
    end
    case (b_mode)
      0:       b_ready_i = 1'b0;
      1:       b_ready_i = 1'b1;
      default: b_ready_i = 1'($urandom_range(1));
    endcase
  endtask

  task automatic tick();
    cyc++;
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic run_until_done(input int budget);
    int n = 0;
    while ((exp_b_q.size() != 0 || exp_wr_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    check("drain_timeout", 64'(exp_b_q.size() + exp_wr_q.size()), 0);
  endtask

  task automatic do_reset();
    bit sa, sw;
    sa = aw_en; sw = w_en;
    aw_en = 0; w_en = 0; aw_valid_i = 0; w_valid_i = 0; rst_i = 1'b1;
    tick();
    aw_drv_q.delete(); w_drv_q.delete(); exp_wr_q.delete(); exp_b_q.delete();
    aw_fired = 0; w_fired = 0; b_held = 0; b_prev_valid = 0;
    rst_i = 1'b0; aw_en = sa; w_en = sw;
    cyc++;
    @(negedge clk);
    check("rst_aw_ready", 64'(aw_ready_o), 0);
    check("rst_w_ready", 64'(w_ready_o), 0);
    check("rst_b_valid", 64'(b_valid_o), 0);
    check("rst_b_chan", 64'(b_chan_o), 0);
    check("rst_wr_valid", 64'(wr_valid_o), 0);
    check("rst_wr_addr", 64'(wr_addr_o), 0);
    check("rst_wr_data", 64'(wr_data_o), 0);
    check("rst_wr_strb", 64'(wr_strb_o), 0);
    @(posedge clk);
    #1;
    drive();
    check("rst_aw_ready_rise", 64'(aw_ready_o), 1);
  endtask

  initial begin
    int base, a0, w0, n;
    logic [1:0] bt;
    int len, size, last_idx;
    logic [31:0] addr;

    do_reset();

    // Single beat with latency checks.
    rand_valid = 0; aw_en = 1; w_en = 1; b_mode = 1;
    base = wr_pulses;
    add_burst(4'd3, 32'h100, 0, 2, BURST_INCR, 0, 32'hcafebabe);
    run_until_done(50);
    repeat (3) tick();
    check("lat_aw_to_w", 64'(w_fire_cyc - aw_fire_cyc), 2);
    check("lat_w_to_wr", 64'(wr_cyc - w_fire_cyc), 1);
    check("lat_w_to_b", 64'(b_rise_cyc - w_fire_cyc), 1);
    check("wr_pulse_count", 64'(wr_pulses - base), 1);

    // INCR, WRAP, FIXED, address wrap at 2^32, early last.
    add_burst(4'd1, 32'h200, 3, 2, BURST_INCR, 3, 0);
    add_burst(4'd4, 32'h108, 3, 2, BURST_WRAP, 3, 0);
    add_burst(4'd7, 32'h400, 2, 2, BURST_FIXED, 2, 0);
    add_burst(4'd5, 32'hFFFF_FFF8, 3, 2, BURST_INCR, 3, 0);
    run_until_done(200);
    base = wr_pulses;
    add_burst(4'd6, 32'h300, 3, 2, BURST_INCR, 2, 0);
    run_until_done(50);
    repeat (3) tick();
    check("mismatch_beats", 64'(wr_pulses - base), 3);

    // Backpressure: 6 AWs against a 4-deep AW queue with B held off.
    b_mode = 0; w_en = 0; aw_en = 1;
    a0 = aw_acc;
    add_burst(4'd2, 32'h500, 0, 2, BURST_INCR, 0, 0);
    add_burst(4'd0, 32'h510, 0, 2, BURST_INCR, 0, 0);
    add_burst(4'd1, 32'h520, 0, 2, BURST_INCR, 0, 0);
    add_burst(4'd3, 32'h530, 0, 2, BURST_INCR, 0, 0);
    add_burst(4'd2, 32'h540, 0, 2, BURST_INCR, 0, 0);
    add_burst(4'd0, 32'h550, 0, 2, BURST_INCR, 0, 0);
    repeat (15) tick();
    check("bp_aw_accepted", 64'(aw_acc - a0), 4);
    check("bp_aw_ready", 64'(aw_ready_o), 0);
    w0 = w_acc; w_en = 1;
    repeat (25) tick();
    check("bp_w_accepted", 64'(w_acc - w0), 4);
    check("bp_w_ready", 64'(w_ready_o), 0);
    check("bp_b_valid", 64'(b_valid_o), 1);
    check("bp_aw_all", 64'(aw_acc - a0), 6);
    b_mode = 1;
    run_until_done(100);

    // Reset after beat 1 of a len=3 burst, then a fresh single beat.
    w0 = w_acc;
    add_burst(4'd9, 32'h600, 3, 2, BURST_INCR, 3, 0);
    n = 0;
    while (w_acc < w0 + 2 && n < 50) begin
      tick();
      n++;
    end
    check("rst_wait_beats", 64'(w_acc - w0), 2);
    do_reset();
    repeat (10) tick();
    check("rst_no_b", 64'(b_valid_o), 0);
    add_burst(4'd10, 32'h700, 0, 2, BURST_INCR, 0, 32'h12345678);
    run_until_done(50);

    // Randomized bursts with random valid/ready.
    rand_valid = 1; b_mode = 2;
    for (int k = 0; k < 40; k++) begin
      bt = 2'($urandom_range(2));
      if (bt == BURST_WRAP) len = (1 << $urandom_range(1, 4)) - 1;
      else len = $urandom_range(0, 15);
      size = $urandom_range(0, 2);
      addr = $urandom;
      addr = addr & ~((32'd1 << size) - 32'd1);
      last_idx = ($urandom_range(4) == 0) ? $urandom_range(0, len) : len;
      add_burst(4'($urandom_range(15)), addr, len, size, bt, last_idx, 0);
    end
    run_until_done(5000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
